// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, sequencer state type and the 4-bit S-box.
package present_pkg;

  localparam int NUM_RK = 32;
  localparam int KEY_W  = 80;
  localparam int RK_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    GEN   = 2'd2,
    DRAIN = 2'd3
  } ks_state_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] n);
    logic [3:0] s;
    case (n)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_schedule.sv
// One PRESENT-80 key-register update: rotate left by 61, S-box on the top
// nibble, XOR the 5-bit round counter into bits 19:15.
module key_schedule
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] x,
  input  logic [4:0]       i,
  output logic [KEY_W-1:0] y
);

  logic [KEY_W-1:0] w_rot;

  assign w_rot = {x[18:0], x[79:19]};

  // Substitute the top nibble and mix in the round counter.
  always_comb begin
    y          = w_rot;
    y[79:76]   = present_sbox(w_rot[79:76]);
    y[19:15]   = w_rot[19:15] ^ i;
  end

endmodule

// File: rtl/present_key_sequencer.sv
// Iterative PRESENT-80 round-key sequencer. Streams rk1..rk32 directly from
// the key register (encryption) or expands all 32 keys into a local buffer
// first and replays them rk32..rk1 (decryption).
//
// state | meaning
// IDLE  | waiting for start; all outputs quiet
// ENC   | presenting kreg[79:16] as rk_rc, advance on handshake
// GEN   | filling mem with rk1..rk32, one per cycle, nothing valid
// DRAIN | presenting mem[rc-1] as rk_rc, count down on handshake
module present_key_sequencer
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec,
  input  logic [KEY_W-1:0] key,
  input  logic             abort,
  output logic [RK_W-1:0]  rk,
  output logic [5:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy,
  output logic             done
);

  ks_state_t        r_state;
  logic [KEY_W-1:0] r_kreg;
  logic [5:0]       r_rc;
  logic [RK_W-1:0]  r_rk;
  logic [5:0]       r_rk_idx;
  logic             r_rk_valid;
  logic             r_busy;
  logic             r_done;
  logic [RK_W-1:0]  r_mem [NUM_RK];

  logic [KEY_W-1:0] w_ks;
  logic             w_hs;
  logic             w_rc_last;
  logic [4:0]       w_wr_idx;
  logic [4:0]       w_rd_idx;
  logic [RK_W-1:0]  w_mem_rd;

  key_schedule u_key_schedule (
    .x (r_kreg),
    .i (r_rc[4:0]),
    .y (w_ks)
  );

  assign w_hs      = r_rk_valid & rk_ready;
  assign w_rc_last = (r_rc == 6'(NUM_RK));
  // rc runs 1..32; the 5-bit wrap makes rc=32 land on slot 31.
  assign w_wr_idx  = r_rc[4:0] - 5'd1;
  // Slot of the key that follows the current one while draining (rc-1).
  assign w_rd_idx  = r_rc[4:0] - 5'd2;
  assign w_mem_rd  = r_mem[w_rd_idx];

  // Sequencer FSM; rk/rk_idx/rk_valid are registered so rk_ready never reaches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_kreg     <= '0;
      r_rc       <= '0;
      r_rk       <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kreg <= key;
            r_rc   <= 6'd1;
            r_busy <= 1'b1;
            if (dec) begin
              r_state <= GEN;
            end else begin
              r_state    <= ENC;
              r_rk_valid <= 1'b1;
              r_rk       <= key[79:16];
              r_rk_idx   <= 6'd1;
            end
          end
        end
        ENC: begin
          if (abort || (w_hs && w_rc_last)) begin
            r_state    <= IDLE;
            r_kreg     <= '0;
            r_rc       <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= !abort;
          end else if (w_hs) begin
            r_kreg   <= w_ks;
            r_rc     <= r_rc + 6'd1;
            r_rk     <= w_ks[79:16];
            r_rk_idx <= r_rc + 6'd1;
          end
        end
        GEN: begin
          if (abort) begin
            r_state  <= IDLE;
            r_kreg   <= '0;
            r_rc     <= '0;
            r_busy   <= 1'b0;
          end else if (w_rc_last) begin
            // rk32 is being written to the buffer this cycle; present it directly.
            r_state    <= DRAIN;
            r_rk_valid <= 1'b1;
            r_rk       <= r_kreg[79:16];
            r_rk_idx   <= r_rc;
          end else begin
            r_kreg <= w_ks;
            r_rc   <= r_rc + 6'd1;
          end
        end
        DRAIN: begin
          if (abort || (w_hs && (r_rc == 6'd1))) begin
            r_state    <= IDLE;
            r_kreg     <= '0;
            r_rc       <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= !abort;
          end else if (w_hs) begin
            r_rc     <= r_rc - 6'd1;
            r_rk     <= w_mem_rd;
            r_rk_idx <= r_rc - 6'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Round-key buffer: filled during GEN, never cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == GEN)) begin
      r_mem[w_wr_idx] <= r_kreg[79:16];
    end
  end

  assign rk       = r_rk;
  assign rk_idx   = r_rk_idx;
  assign rk_valid = r_rk_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_present_key_sequencer.sv
// Bench for present_key_sequencer: directed scenarios with random keys and
// random back-pressure, checked against a PRESENT-80 key-schedule model.
module tb_present_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dec;
  logic [79:0] key;
  logic        abort;
  logic [63:0] rk;
  logic [5:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] exp_rk [0:32];
  logic [63:0] got    [0:32];
  int          sb     [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  present_key_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dec      (dec),
    .key      (key),
    .abort    (abort),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: round key i is the top 64 bits of the key after i-1 updates.
  task automatic build_model(input logic [79:0] k);
    logic [79:0] s;
    logic [3:0]  top;
    s = k;
    for (int r = 1; r <= 32; r++) begin
      exp_rk[r] = s[79:16];
      s   = (s << 61) | (s >> 19);
      top = s[79:76];
      s[79:76] = 4'(sb[top]);
      s[19:15] = s[19:15] ^ 5'(r);
    end
  endtask

  function automatic logic [79:0] rnd80();
    logic [31:0] a, b, c;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    return {a, b, c[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full expansion; call with the DUT idle or in its done cycle.
  task automatic run(input logic [79:0] k, input bit d, input bit stall, input int poke_at);
    int t0, acc, guard, ei;
    build_model(k);
    key = k; dec = d; start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("busy_after_start", 80'(busy), 80'd1);
    if (d) begin
      for (int c = 0; c < 32; c++) begin
        chk("gen_no_valid", 80'(rk_valid), 80'd0);
        chk("gen_idx_zero", 80'(rk_idx), 80'd0);
        tick();
      end
    end
    acc = 0; guard = 0;
    while (acc < 32 && guard < 400) begin
      ei = d ? 32 - acc : acc + 1;
      chk("rk_valid", 80'(rk_valid), 80'd1);
      chk("rk_idx", 80'(rk_idx), 80'(ei));
      chk("rk", 80'(rk), 80'(exp_rk[ei]));
      chk("no_early_done", 80'(done), 80'd0);
      got[ei] = rk;
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (guard == poke_at) begin
        start = 1'b1; key = ~k; dec = ~d;
      end
      tick();
      start = 1'b0;
      if (rk_ready) acc++;
      guard++;
    end
    if (guard >= 400) chk("timeout_keys_accepted", 80'(acc), 80'd32);
    rk_ready = 1'b0;
    chk("done_pulse", 80'(done), 80'd1);
    chk("busy_end", 80'(busy), 80'd0);
    chk("valid_end", 80'(rk_valid), 80'd0);
    chk("rk_end", 80'(rk), 80'd0);
    // start at edge t0: ENC last handshake at edge t0+32, DEC at t0+64
    if (!stall) chk("done_latency", 80'(cyc - t0), d ? 80'd64 : 80'd32);
  endtask

  initial begin
    logic [79:0] k;
    rst_n = 1'b0; start = 1'b0; dec = 1'b0; key = '0; abort = 1'b0; rk_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 80'(rk_valid), 80'd0);
    chk("rst_rk", 80'(rk), 80'd0);
    chk("rst_idx", 80'(rk_idx), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_done", 80'(done), 80'd0);
    rst_n = 1'b1;
    tick();

    // Zero key, encryption, known test-vector keys.
    run(80'd0, 1'b0, 1'b0, -1);
    chk("enc0_rk1", 80'(got[1]), 80'h0);
    chk("enc0_rk2", 80'(got[2]), 80'hC000000000000000);
    chk("enc0_rk32", 80'(got[32]), 80'h6DAB31744F41D700);

    // Decryption started in the done cycle of the previous run.
    run(80'd0, 1'b1, 1'b0, -1);
    chk("dec0_first", 80'(got[32]), 80'h6DAB31744F41D700);
    chk("dec0_last", 80'(got[1]), 80'h0);

    // All-ones key with random back-pressure, then start pokes while busy.
    run({80{1'b1}}, 1'b0, 1'b1, -1);
    run(rnd80(), 1'b0, 1'b0, 5);
    run(rnd80(), 1'b1, 1'b1, 40);
    tick();

    // Abort at rk_idx 10, then a decryption with a fresh key.
    key = rnd80(); dec = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; rk_ready = 1'b1;
    for (int c = 0; c < 20 && rk_idx != 6'd10; c++) tick();
    chk("abort_reach_idx10", 80'(rk_idx), 80'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0; rk_ready = 1'b0;
    chk("abort_valid", 80'(rk_valid), 80'd0);
    chk("abort_busy", 80'(busy), 80'd0);
    chk("abort_no_done", 80'(done), 80'd0);
    tick();
    chk("abort_no_done2", 80'(done), 80'd0);
    run(rnd80(), 1'b1, 1'b0, -1);

    // Reset pulse during GEN at rc = 17.
    key = rnd80(); dec = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 80'(rk_valid), 80'd0);
    chk("mid_rst_rk", 80'(rk), 80'd0);
    chk("mid_rst_idx", 80'(rk_idx), 80'd0);
    chk("mid_rst_busy", 80'(busy), 80'd0);
    chk("mid_rst_done", 80'(done), 80'd0);
    run(rnd80(), 1'b0, 1'b0, -1);

    // A few more random runs in both directions.
    for (int n = 0; n < 3; n++) begin
      k = rnd80();
      run(k, 1'(n & 1), 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/present_key_sequencer.md
# present_key_sequencer

- Iterative round-key controller for the PRESENT-80 cipher.
- Owns an 80-bit key register and advances it one round per step through the existing `key_schedule` update.
- Streams the 32 64-bit round keys to the round datapath over a valid/ready handshake.
- Order is ascending (encryption) or descending (decryption); decryption is served from an internal 32-entry buffer.

## Interface

Parameters:
- none; widths are fixed by PRESENT-80.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request a new key expansion; sampled only in IDLE.
- `dec` in 1: order select, sampled with `start`; 0 = rk1..rk32, 1 = rk32..rk1.
- `key` in 80: cipher key, sampled with `start`.
- `abort` in 1: cancel the current expansion; ignored in IDLE.
- `rk` out 64: current round key; reads 0 whenever `rk_valid` = 0.
- `rk_idx` out 6: index 1..32 of `rk`; reads 0 whenever `rk_valid` = 0.
- `rk_valid` out 1: `rk` and `rk_idx` are valid.
- `rk_ready` in 1: consumer accepts `rk` this cycle.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse after the last round key is accepted.

## Operation

- Registers:
  - `kreg[79:0]`: key register.
  - `rc[5:0]`: round counter.
  - `mem`: 32 × 64 buffer.
  - `state`: one of IDLE, ENC, GEN, DRAIN.
- Update rule: `kreg <= key_schedule(kreg, rc[4:0])`.
  - Applied only for `rc` in 1..31.
  - Never applied at `rc` = 32.
- Round key `rk_i` = `kreg[79:16]` at the point where `rc` = i.
- IDLE, on `start`:
  - `kreg <= key`, `rc <= 1`, latch `dec`.
  - Next state GEN if `dec`, else ENC.
- ENC:
  - Outputs: `rk_valid` = 1, `rk` = `kreg[79:16]`, `rk_idx` = `rc`.
  - On handshake with `rc` = 32: go to IDLE and pulse `done`.
  - On handshake with `rc` < 32: update `kreg`, `rc <= rc+1`.
  - No handshake: hold all registers.
- GEN:
  - Every cycle: `mem[rc-1] <= kreg[79:16]`. `rk_valid` = 0.
  - `rc` < 32: update `kreg`, `rc <= rc+1`.
  - `rc` = 32: `rc <= 32` and go to DRAIN.
  - GEN lasts exactly 32 cycles.
- DRAIN:
  - Outputs: `rk_valid` = 1, `rk` = `mem[rc-1]`, `rk_idx` = `rc`.
  - On handshake with `rc` = 1: go to IDLE and pulse `done`.
  - On handshake with `rc` > 1: `rc <= rc-1`.
- `abort` high in ENC, GEN or DRAIN:
  - Next state IDLE.
  - No `done`.
  - Pending key discarded.
  - `mem` contents left stale; this is don't-care.
- `start` outside IDLE is ignored. No queuing.
- Reset (`rst_n` low at an edge) from any state:
  - Next cycle: IDLE, `kreg` = 0, `rc` = 0, `rk` = 0, `rk_idx` = 0, `rk_valid` = 0, `busy` = 0, `done` = 0.
  - `mem` is not cleared.
  - Reset has priority over `abort` and `start`.

## Timing

- `start` accepted at edge t:
  - `busy` = 1 from t+1.
  - ENC: `rk1` valid at t+1.
  - DEC: `rk32` valid at t+33.
- Back-to-back throughput with `rk_ready` held high: one key per cycle.
  - ENC: the final handshake is at cycle t+32.
  - DEC: the final handshake is at cycle t+64.
- `done` = 1 and `busy` = 0 in the cycle after the final handshake.
  - A `start` in that same cycle is accepted.
- Handshake rules:
  - `rk_valid`, `rk` and `rk_idx` are driven from registers and state only.
  - No combinational path from `rk_ready` to them.
  - Once `rk_valid` is high, it and `rk`/`rk_idx` stay stable until the handshake or `abort`/reset.

## Structure

- Shared package `present_pkg`:
  - `NUM_RK` = 32.
  - `KEY_W` = 80.
  - `RK_W` = 64.
  - State enum `ks_state_t` (IDLE, ENC, GEN, DRAIN).
- One sub-module: the existing `key_schedule`, instantiated once.
  - Inputs: `x` = `kreg`, `i` = `rc[4:0]`.
  - Its output feeds the `kreg` next-state mux.
- `mem` is a flop array with a combinational read indexed by `rc-1`, used in DRAIN.

## Test plan

- ENC, `key` = 0, `rk_ready` = 1:
  - `rk1` = 0x0000000000000000.
  - `rk2` = 0xC000000000000000.
  - `rk32` = 0x6DAB31744F41D700.
  - `done` at t+33.
  - All 32 keys match the software model.
- DEC, `key` = 0:
  - No `rk_valid` during t+1..t+32.
  - `rk_idx` sequence 32..1.
  - First key 0x6DAB31744F41D700, last key 0.
  - `done` at t+65.
- ENC, `key` = 0xFFFF…FF, `rk_ready` random 50% duty:
  - `rk`/`rk_idx` stable while stalled.
  - The 32 accepted keys equal the unstalled sequence.
- `abort` at ENC `rk_idx` 10, then `start` DEC with a new key two cycles later:
  - No `done` for the aborted run.
  - The new sequence is correct.
- `rst_n` low for one cycle during GEN at `rc` = 17:
  - Every output reads its reset value in the following cycle.
  - A subsequent ENC run is correct.
- `start` pulsed while busy:
  - Ignored; the running sequence is unaffected.
- `start` in the `done` cycle:
  - Accepted; the next run's `rk1` is valid the cycle after.
